// File: rtl/tc_timer.sv
`default_nettype none
// ============================================================================
// Module   : tc_timer
// Brief    : Memory-mapped timer/counter with CTRL/PRESET/COUNT and one irq.
//            Optional macro TC_PRESCALE_EN adds an 8-bit PRESCALE at addr 3.
// Revision : 1.0 - initial release
// ============================================================================
module tc_timer #(
    parameter logic [31:0] PRESET_RST = 32'd0,
    parameter logic [3:0]  CTRL_MASK  = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_preset = 2'd1;
    localparam logic [1:0] c_addr_count  = 2'd2;
    localparam logic [1:0] c_addr_aux    = 2'd3;
    localparam logic [1:0] c_mode_reload = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_ctrl, w_ctrl_next;
    logic [31:0] r_preset, w_preset_next;
    logic [31:0] r_count, w_count_next;
    logic        r_pend, w_pend_next;
    logic        r_irq;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_en;
    logic [1:0]  w_mode;
    logic        w_tick;

    assign w_wr      = sel & we;
    assign w_wr_ctrl = w_wr & (addr == c_addr_ctrl);
    assign w_en      = r_ctrl[0];
    assign w_mode    = r_ctrl[2:1];

`ifdef TC_PRESCALE_EN
    logic [7:0] r_prescale;
    logic [7:0] r_div, w_div_next;

    assign w_tick = (r_div == r_prescale);

    // Divider only advances while actively counting; any other state restarts it.
    always_comb begin
        w_div_next = 8'd0;
        if (r_state == ST_CNT && w_en && !w_tick) begin
            w_div_next = r_div + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prescale <= 8'd0;
            r_div      <= 8'd0;
        end else begin
            r_div <= w_div_next;
            if (w_wr && addr == c_addr_aux) begin
                r_prescale <= wdata[7:0];
            end
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_ctrl_next   = r_ctrl;
        w_count_next  = r_count;
        w_pend_next   = r_pend;
        w_preset_next = r_preset;

        case (r_state)
            ST_IDLE: begin
                if (w_en) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count_next = r_preset;
                w_state_next = w_en ? ST_CNT : ST_IDLE;
            end
            ST_CNT: begin
                // Zero is caught before decrementing, so COUNT never wraps.
                if (!w_en) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (r_count == 32'd0) begin
                        w_state_next = ST_INT;
                        w_pend_next  = 1'b1;
                    end else begin
                        w_count_next = r_count - 32'd1;
                    end
                end
            end
            ST_INT: begin
                if (w_mode == c_mode_reload) begin
                    w_pend_next  = 1'b0;
                    w_state_next = w_en ? ST_LOAD : ST_IDLE;
                end else begin
                    w_ctrl_next[0] = 1'b0;
                    w_state_next   = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // CPU writes take priority over the hardware EN-clear and pend-set.
        if (w_wr_ctrl) begin
            w_ctrl_next = wdata[3:0] & CTRL_MASK;
            w_pend_next = 1'b0;
        end
        if (w_wr && addr == c_addr_preset) begin
            w_preset_next = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= 4'd0;
            r_preset <= PRESET_RST;
            r_count  <= 32'd0;
            r_pend   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ctrl   <= w_ctrl_next;
            r_preset <= w_preset_next;
            r_count  <= w_count_next;
            r_pend   <= w_pend_next;
            r_irq    <= w_pend_next & w_ctrl_next[3];
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr)
                c_addr_ctrl:   rdata = {28'd0, r_ctrl};
                c_addr_preset: rdata = r_preset;
                c_addr_count:  rdata = r_count;
                c_addr_aux: begin
`ifdef TC_PRESCALE_EN
                    rdata = {24'd0, r_prescale};
`else
                    rdata = 32'd0;
`endif
                end
                default:       rdata = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_timer
// Brief    : Scoreboard bench for tc_timer with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    wire  [31:0] rdata;
    wire         irq;

    tc_timer dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: timer phase plus the software-visible registers.
    localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;
    int        m_phase;
    bit [3:0]  m_ctrl;
    bit [31:0] m_preset, m_count;
    bit        m_pend, m_irq;
    bit [7:0]  m_prescale, m_div;

    task automatic model_reset();
        m_phase = P_IDLE; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
        m_pend = 1'b0; m_irq = 1'b0; m_prescale = 8'd0; m_div = 8'd0;
    endtask

    // Applies one rising edge using the bus inputs held across that edge.
    task automatic model_edge();
        bit       en;
        bit [1:0] mode;
        bit       tick;
        int       nphase;
        if (!reset) begin
            model_reset();
            return;
        end
        en     = m_ctrl[0];
        mode   = m_ctrl[2:1];
        tick   = (m_div == m_prescale);
        nphase = m_phase;
        case (m_phase)
            P_IDLE: begin m_div = 0; if (en) nphase = P_LOAD; end
            P_LOAD: begin m_div = 0; m_count = m_preset; nphase = en ? P_CNT : P_IDLE; end
            P_CNT: begin
                if (!en) begin
                    nphase = P_IDLE; m_div = 0;
                end else if (tick) begin
                    m_div = 0;
                    if (m_count == 0) begin nphase = P_INT; m_pend = 1; end
                    else m_count = m_count - 1;
                end else begin
                    m_div = m_div + 1;
                end
            end
            default: begin
                m_div = 0;
                if (mode == 2'b01) begin m_pend = 0; nphase = en ? P_LOAD : P_IDLE; end
                else begin m_ctrl[0] = 1'b0; nphase = P_IDLE; end
            end
        endcase
        if (sel && we) begin
            if (addr == 2'd0) begin m_ctrl = wdata[3:0]; m_pend = 0; end
            if (addr == 2'd1) m_preset = wdata;
`ifdef TC_PRESCALE_EN
            if (addr == 2'd3) m_prescale = wdata[7:0];
`endif
        end
        m_irq   = m_pend & m_ctrl[3];
        m_phase = nphase;
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.irq   = m_irq;
        e.rdata = 32'd0;
        if (sel) begin
            case (addr)
                2'd0: e.rdata = {28'd0, m_ctrl};
                2'd1: e.rdata = m_preset;
                2'd2: e.rdata = m_count;
                default: e.rdata = {24'd0, m_prescale};
            endcase
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic drive(input bit s, input bit w, input bit [1:0] a, input bit [31:0] d);
        sel = s; we = w; addr = a; wdata = d;
        sb_q.push_back(predict());
    endtask

    task automatic cyc(input bit s, input bit w, input bit [1:0] a, input bit [31:0] d);
        step();
        drive(s, w, a, d);
    endtask

    task automatic wr(input bit [1:0] a, input bit [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd_n(input bit [1:0] a, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, a, 32'd0);
    endtask

    // Reset pulsed low between edges; its effect is sampled before the next edge.
    task automatic reset_pulse();
        step();
        drive(1'b1, 1'b0, 2'd2, 32'd0);
        #1 reset = 1'b0;
        model_reset();
        void'(sb_q.pop_back());
        sb_q.push_back(predict());
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (rdata !== e.rdata) begin
                errors++;
                $display("FAIL rdata: got %h expected %h (addr %0d sel %0b) at %0t",
                         rdata, e.rdata, addr, sel, $time);
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL irq: got %0b expected %0b at %0t", irq, e.irq, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        model_reset();
        rd_n(2'd0, 2);
        @(negedge clk); #1 reset = 1'b1;

        // Reset values
        rd_n(2'd0, 1); rd_n(2'd1, 1); rd_n(2'd2, 1); rd_n(2'd3, 1);

        // One-shot, IM=1, then clear pend by CTRL write
        wr(2'd1, 32'd5); wr(2'd0, 32'h9);
        rd_n(2'd2, 12); rd_n(2'd0, 3);
        wr(2'd0, 32'h8); rd_n(2'd0, 3);

        // Auto-reload, stop mid-count
        wr(2'd1, 32'd2); wr(2'd0, 32'hB);
        rd_n(2'd2, 17);
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_phase == P_CNT && m_count == 1) begin drive(1'b1, 1'b1, 2'd0, 32'h0); break; end
            drive(1'b1, 1'b0, 2'd2, 32'd0);
        end
        rd_n(2'd2, 8);

        // One-shot, IM=0, then IM alone
        wr(2'd1, 32'd5); wr(2'd0, 32'h1);
        rd_n(2'd0, 12); wr(2'd0, 32'h8); rd_n(2'd0, 4);

        // CPU CTRL write coinciding with pend-set edge, then with the INT edge
        wr(2'd1, 32'd3); wr(2'd0, 32'h9);
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_phase == P_CNT && m_count == 0) begin drive(1'b1, 1'b1, 2'd0, 32'hD); break; end
            drive(1'b1, 1'b0, 2'd2, 32'd0);
        end
        rd_n(2'd0, 2);
        wr(2'd0, 32'h0); wr(2'd1, 32'd1); wr(2'd0, 32'h9);
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_phase == P_INT) begin drive(1'b1, 1'b1, 2'd0, 32'hF); break; end
            drive(1'b1, 1'b0, 2'd0, 32'd0);
        end
        rd_n(2'd0, 3);
        wr(2'd2, 32'h1234); rd_n(2'd2, 2);
        wr(2'd0, 32'h0); wr(2'd3, 32'hFF); rd_n(2'd3, 2);

        // Reset mid-count
        wr(2'd1, 32'd20); wr(2'd0, 32'h9); rd_n(2'd2, 6);
        reset_pulse();
        rd_n(2'd0, 1); rd_n(2'd1, 1); rd_n(2'd2, 1);

        // Randomized traffic
        for (int n = 0; n < 700; n++) begin
            r = $urandom_range(0, 63);
            if (r < 4)       wr(2'd0, {$urandom_range(0, 15)} | 32'h1);
            else if (r < 5)  wr(2'd0, $urandom);
            else if (r < 8)  wr(2'd1, $urandom_range(0, 6));
            else if (r < 9)  wr(2'($urandom_range(2, 3)), $urandom_range(0, 3));
            else if (r < 11) cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom);
            else if (r < 12) reset_pulse();
            else             cyc($urandom_range(0, 7) != 0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
        end

        rd_n(2'd0, 2);
        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d leftover entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
